// File: rtl/iig_pkg.sv
// ============================================================================
// iig_pkg : shared state encoding and counter-width helpers for the IIG control
// Revision: 1.0
// ============================================================================
`default_nettype none

package iig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int col_w(input int img_w);
        return cnt_w(img_w);
    endfunction

    function automatic int row_w(input int img_h);
        return cnt_w(img_h);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iig_pos_counter.sv
// ============================================================================
// iig_pos_counter : column/row pixel position counter with wrap flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module iig_pos_counter
    import iig_pkg::*;
#(
    parameter int IMG_W = 80,
    parameter int IMG_H = 60
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    output logic [col_w(IMG_W)-1:0]    col,
    output logic [row_w(IMG_H)-1:0]    row,
    output logic                       col_last,
    output logic                       row_last
);

    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);

    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iig_frame_ctrl.sv
// ============================================================================
// iig_frame_ctrl : frame sequencer for the integral-image generator datapath
// Optional sticky overflow/protocol error port oErr under IIG_OVF_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iig_frame_ctrl
    import iig_pkg::*;
#(
    parameter int IMG_W      = 80,
    parameter int IMG_H      = 60,
    parameter int ADDR_W     = 13,
    parameter int PIPE_LAT   = 2,
    parameter int CONTINUOUS = 0
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iRun,
    input  logic              iInput_ready,
    input  logic              iFull_BUF,
    input  logic              iEmpty_BUF,
    output logic              oInt_rst_MAC,
    output logic              oReady_MAC,
    output logic              oSelect_BUF,
    output logic              oRdreq_BUF,
    output logic              oWrreq_BUF,
    output logic              oEnable_SUM,
    output logic [ADDR_W-1:0] oAddr_IIGBRAM,
    output logic              oOutput_ready,
    output logic              oFrame_done,
    output logic              oBusy
`ifdef IIG_OVF_CHECK_EN
    ,
    output logic              oErr
`endif
);

    localparam int COL_W = col_w(IMG_W);
    localparam int ROW_W = row_w(IMG_H);
    localparam int DRN_W = cnt_w(PIPE_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(PIPE_LAT - 1);

    state_t              state;
    state_t              state_nx;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                col_last;
    logic                row_last;
    logic                accept;
    logic                drain_last;
    logic                wr_last;
    logic [DRN_W-1:0]    drain_cnt;
    logic [PIPE_LAT-1:0] pipe;
    logic                ready_mac;
    logic                wrreq;
    logic                enable_sum;
    logic                select;
    logic                frame_done;
    logic [ADDR_W-1:0]   addr;

    assign accept     = iInput_ready & (state == ST_ACTIVE);
    assign drain_last = (state == ST_DRAIN) & (drain_cnt == DRN_LAST);

    iig_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk      (iClk),
        .rst_n    (iReset_n),
        .clr      (~iRun),
        .en       (accept),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) state <= ST_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (iRun) state_nx = ST_ACTIVE;
            ST_ACTIVE: if (accept && col_last && row_last) state_nx = ST_DRAIN;
            ST_DRAIN:  if (drain_last) state_nx = ST_DONE;
            ST_DONE:   if (CONTINUOUS != 0) state_nx = ST_ACTIVE;
            default:   state_nx = ST_IDLE;
        endcase
        // Dropping iRun aborts from any state, including the frame-end cycle.
        if (!iRun) state_nx = ST_IDLE;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            pipe       <= '0;
            ready_mac  <= 1'b0;
            wrreq      <= 1'b0;
            wr_last    <= 1'b0;
            drain_cnt  <= '0;
            frame_done <= 1'b0;
            enable_sum <= 1'b0;
            select     <= 1'b0;
            addr       <= '0;
        end else if (!iRun) begin
            pipe       <= '0;
            ready_mac  <= 1'b0;
            wrreq      <= 1'b0;
            wr_last    <= 1'b0;
            drain_cnt  <= '0;
            frame_done <= 1'b0;
            enable_sum <= 1'b0;
            select     <= 1'b0;
            addr       <= '0;
        end else begin
            pipe       <= (pipe << 1) | PIPE_LAT'(accept);
            ready_mac  <= accept;
            // The last row is never read back, so its column sums are not stored.
            wrreq      <= accept & ~row_last;
            wr_last    <= accept & col_last & ~row_last;
            drain_cnt  <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            frame_done <= drain_last;
            if (drain_last)
                enable_sum <= 1'b0;
            else if (accept && (row == ROW_W'(1)) && (col == '0))
                enable_sum <= 1'b1;
            if ((state == ST_IDLE) || (state == ST_DONE))
                select <= 1'b0;
            else if (wr_last)
                select <= ~select;
            if (oOutput_ready)
                addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
        end
    end

    assign oInt_rst_MAC  = accept & (col == '0);
    assign oRdreq_BUF    = accept & (row != '0);
    assign oReady_MAC    = ready_mac;
    assign oWrreq_BUF    = wrreq;
    assign oEnable_SUM   = enable_sum;
    assign oSelect_BUF   = select;
    assign oAddr_IIGBRAM = addr;
    assign oOutput_ready = pipe[PIPE_LAT-1] & iRun;
    assign oFrame_done   = frame_done;
    assign oBusy         = (state == ST_ACTIVE) | (state == ST_DRAIN);

`ifdef IIG_OVF_CHECK_EN
    logic err;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n)
            err <= 1'b0;
        else if (!iRun)
            err <= 1'b0;
        else if ((wrreq & iFull_BUF) | (oRdreq_BUF & iEmpty_BUF) |
                 (iInput_ready & (state != ST_ACTIVE)))
            err <= 1'b1;
    end

    assign oErr = err;
`else
    logic unused_buf_flags;
    assign unused_buf_flags = &{1'b0, iFull_BUF, iEmpty_BUF};
`endif

endmodule

`default_nettype wire

// File: tb/tb_iig_frame_ctrl.sv
// ============================================================================
// tb_iig_frame_ctrl : self-checking bench for iig_frame_ctrl (4x3 frame)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iig_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int PL = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, vld = 1'b0, full = 1'b0, empty = 1'b0;

    logic int_rst, rmac, sel, rd, wr, en, outr, done, busy;
    logic [AW-1:0] addr;
    logic int_rst2, rmac2, sel2, rd2, wr2, en2, outr2, done2, busy2;
    logic [AW-1:0] addr2;
`ifdef IIG_OVF_CHECK_EN
    logic err, err2;
`endif

    always #5 clk = ~clk;

    iig_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(PL), .CONTINUOUS(0)) dut (
        .iClk(clk), .iReset_n(rst_n), .iRun(run), .iInput_ready(vld),
        .iFull_BUF(full), .iEmpty_BUF(empty),
        .oInt_rst_MAC(int_rst), .oReady_MAC(rmac), .oSelect_BUF(sel), .oRdreq_BUF(rd),
        .oWrreq_BUF(wr), .oEnable_SUM(en), .oAddr_IIGBRAM(addr), .oOutput_ready(outr),
        .oFrame_done(done), .oBusy(busy)
`ifdef IIG_OVF_CHECK_EN
        , .oErr(err)
`endif
    );

    iig_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(PL), .CONTINUOUS(1)) dut_c (
        .iClk(clk), .iReset_n(rst_n), .iRun(run), .iInput_ready(vld),
        .iFull_BUF(full), .iEmpty_BUF(empty),
        .oInt_rst_MAC(int_rst2), .oReady_MAC(rmac2), .oSelect_BUF(sel2), .oRdreq_BUF(rd2),
        .oWrreq_BUF(wr2), .oEnable_SUM(en2), .oAddr_IIGBRAM(addr2), .oOutput_ready(outr2),
        .oFrame_done(done2), .oBusy(busy2)
`ifdef IIG_OVF_CHECK_EN
        , .oErr(err2)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a timeline of future events keyed by cycle number.
    int pix, res, t_last;
    bit prev_run, m_en, m_sel;
    bit s_rmac[16], s_wr[16], s_out[16], s_tog[16], s_done[16], s_eset[16], s_eclr[16];

    task automatic clear_slot(input int s);
        s_rmac[s] = 0; s_wr[s] = 0; s_out[s] = 0; s_tog[s] = 0;
        s_done[s] = 0; s_eset[s] = 0; s_eclr[s] = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) clear_slot(i);
        pix = 0; res = 0; t_last = -100; m_en = 0; m_sel = 0;
    endtask

    task automatic step(input bit r, input bit v, input bit f, input bit e);
        int  sl;
        bit  active, acc;
        @(negedge clk);
        run = r; vld = v; full = f; empty = e;
        #1;
        sl = cyc % 16;
        if (s_tog[sl])  m_sel = ~m_sel;
        if (s_eset[sl]) m_en = 1;
        if (s_eclr[sl]) m_en = 0;
        active = prev_run && (pix < N);
        acc    = v && active;
        chk("int_rst_mac", int_rst, int'(acc && (pix % W == 0)));
        chk("rdreq_buf",   rd,      int'(acc && (pix >= W)));
        chk("ready_mac",   rmac,    int'(s_rmac[sl]));
        chk("wrreq_buf",   wr,      int'(s_wr[sl]));
        chk("output_ready", outr,   int'(s_out[sl] && r));
        chk("addr",        addr,    res % N);
        chk("frame_done",  done,    int'(s_done[sl]));
        chk("enable_sum",  en,      int'(m_en));
        chk("select_buf",  sel,     int'(m_sel));
        chk("busy",        busy,    int'(prev_run && ((pix < N) || (cyc <= t_last + PL))));
        if (!r) begin
            clear_model();
        end else begin
            if (s_out[sl]) res++;
            clear_slot(sl);
            if (acc) begin
                s_rmac[(cyc + 1) % 16] = 1;
                if (pix < W * (H - 1)) s_wr[(cyc + 1) % 16] = 1;
                s_out[(cyc + PL) % 16] = 1;
                if ((pix % W == W - 1) && (pix < W * (H - 1))) s_tog[(cyc + 2) % 16] = 1;
                if (pix == W) s_eset[(cyc + 1) % 16] = 1;
                if (pix == N - 1) begin
                    s_done[(cyc + PL + 1) % 16] = 1;
                    s_eclr[(cyc + PL + 1) % 16] = 1;
                    t_last = cyc;
                end
                pix++;
            end
        end
        prev_run = r;
        cyc++;
    endtask

    typedef struct {
        bit r; bit v;
        bit e_int; bit e_rd; bit e_out; int e_addr; bit e_done; bit e_busy;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_out, n_done, tog, exp_c;
        bit last_sel, found;

        for (int c = 0; c < 18; c++) begin
            tbl[c].r      = 1;
            tbl[c].v      = (c >= 1 && c <= 12) || (c >= 16);
            tbl[c].e_int  = (c >= 1 && c <= 12) && ((c - 1) % W == 0);
            tbl[c].e_rd   = (c >= 1 && c <= 12) && ((c - 1) >= W);
            tbl[c].e_out  = (c >= 3 && c <= 14);
            tbl[c].e_addr = (c >= 3 && c <= 14) ? c - 3 : 0;
            tbl[c].e_done = (c == 15);
            tbl[c].e_busy = (c >= 1 && c <= 14);
        end

        clear_model();
        prev_run = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_int_rst", int_rst, 0); chk("rst_ready_mac", rmac, 0);
        chk("rst_select", sel, 0);      chk("rst_rdreq", rd, 0);
        chk("rst_wrreq", wr, 0);        chk("rst_enable_sum", en, 0);
        chk("rst_addr", addr, 0);       chk("rst_output_ready", outr, 0);
        chk("rst_frame_done", done, 0); chk("rst_busy", busy, 0);
        chk("rst_busy_c", busy2, 0);    chk("rst_addr_c", addr2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back frame from the vector table.
        tog = 0;
        last_sel = 0;
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].v, 1'b0, 1'b0);
            chk("tv_int_rst", int_rst, tbl[i].e_int);
            chk("tv_rdreq",   rd,      tbl[i].e_rd);
            chk("tv_out",     outr,    tbl[i].e_out);
            chk("tv_addr",    addr,    tbl[i].e_addr);
            chk("tv_done",    done,    tbl[i].e_done);
            chk("tv_busy",    busy,    tbl[i].e_busy);
            if (sel != last_sel) tog++;
            last_sel = sel;
        end
        chk("select_toggles", tog, 2);

        // Pixel every other cycle.
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        n_out = 0; n_done = 0;
        for (int i = 0; i < 34; i++) begin
            step(1, i[0], 0, 0);
            if (outr) begin
                chk("gap_addr", addr, n_out);
                n_out++;
            end
            if (done) n_done++;
        end
        chk("gap_results", n_out, N);
        chk("gap_done_pulses", n_done, 1);

        // Abort after pixel 6, then restart.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("abort_busy", busy, 0);   chk("abort_out", outr, 0);
        chk("abort_addr", addr, 0);   chk("abort_sel", sel, 0);
        chk("abort_en", en, 0);       chk("abort_rmac", rmac, 0);
        step(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0);
            if (outr && !found) begin
                chk("restart_addr", addr, 0);
                found = 1;
            end
        end
        chk("restart_out_seen", found, 1);

        // Continuous instance: two frames from one long burst.
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        n_out = 0; n_done = 0; exp_c = 0;
        for (int i = 0; i < 32; i++) begin
            step(1, (i < 31), 0, 0);
            if (outr2) begin
                chk("cont_addr", addr2, exp_c % N);
                exp_c++;
            end
            if (done2) n_done++;
        end
        chk("cont_results", exp_c, 2 * N);
        chk("cont_done_pulses", n_done, 2);
        step(0, 0, 0, 0); step(0, 0, 0, 0);

`ifdef IIG_OVF_CHECK_EN
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("err_before_full", err, 0);
        step(1, 0, 0, 0);
        chk("err_set", err, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("err_sticky", err, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("err_cleared", err, 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 65,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
